// File: rtl/dram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_access_arbiter
// Description : Shares a single-port data RAM between the CPU load/store path
//               and the UART image loader. One requester is granted at a time.
//               The block drives one RAM enable cycle per access, waits out the
//               RAM read latency, and returns registered read data with a
//               one-cycle done pulse. The CPU wins contention while running.
//               The UART wins contention while the CPU sits in PAUSE.
// Ports       : clk, rst                   - clock, async active-high reset
//               cpu_paused                 - selects UART priority on contention
//               cpu_req/we/addr/wdata      - CPU request group (level request)
//               cpu_rdata, cpu_done        - CPU read data, completion pulse
//               uart_req/we/addr/wdata     - UART request group
//               uart_rdata, uart_done      - UART read data, completion pulse
//               ram_en/we/addr/wdata       - RAM command interface
//               ram_rdata                  - RAM read data
//               busy, owner                - status: not idle, last grant (1=UART)
// Revision    : 1.0 - initial release
// ============================================================================
module dram_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_paused,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] c_rd_lat = 3'(RD_LAT);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_cnt;
  logic                r_we;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_uart_rdata;

  logic                w_any_req;
  logic                w_pick_uart;
  logic                w_grant;
  logic                w_capture;

  // UART wins when it is the only requester, or when both request while the
  // CPU is paused.
  assign w_any_req   = cpu_req | uart_req;
  assign w_pick_uart = uart_req & (~cpu_req | cpu_paused);
  assign w_grant     = (r_state == S_IDLE) & w_any_req;
  // Counter was loaded with RD_LAT at the end of ACCESS; reaching 1 marks the
  // edge at which RAM read data is valid.
  assign w_capture   = (r_state == S_WAIT) & (r_cnt == 3'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_DONE : S_WAIT;
      S_WAIT:   if (w_capture) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 3'd0;
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_uart_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner     <= w_pick_uart;
        r_we        <= w_pick_uart ? uart_we    : cpu_we;
        r_ram_addr  <= w_pick_uart ? uart_addr  : cpu_addr;
        r_ram_wdata <= w_pick_uart ? uart_wdata : cpu_wdata;
      end
      if ((r_state == S_ACCESS) && !r_we) begin
        r_cnt <= c_rd_lat;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture) begin
        if (r_owner) begin
          r_uart_rdata <= ram_rdata;
        end else begin
          r_cpu_rdata <= ram_rdata;
        end
      end
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign ram_en     = (r_state == S_ACCESS);
  assign ram_we     = (r_state == S_ACCESS) & r_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign cpu_done   = (r_state == S_DONE) & ~r_owner;
  assign uart_done  = (r_state == S_DONE) &  r_owner;
  assign cpu_rdata  = r_cpu_rdata;
  assign uart_rdata = r_uart_rdata;
  assign busy       = (r_state != S_IDLE);
  assign owner      = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_access_arbiter
// Description : Self-checking bench for dram_access_arbiter with a 2-stage
//               latency RAM model, a table of directed transactions and
//               hand-written reset / back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_access_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_paused = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              uart_req = 1'b0, uart_we = 1'b0;
  logic [ADDR_W-1:0] uart_addr = '0;
  logic [DATA_W-1:0] uart_wdata = '0;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_done;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy, owner;

  dram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .cpu_paused(cpu_paused),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_done(uart_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // RAM model: data sampled at the edge closing the enable cycle, then one more
  // register stage, giving valid data RD_LAT=2 cycles after the enable cycle.
  logic [7:0] mem [0:1023];
  logic [7:0] s1 = '0, s2 = '0;
  assign ram_rdata = s2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'h3C;
      mem[10'h200] <= 8'h96;
      mem[10'h300] <= 8'hE1;
      mem[10'h040] <= 8'h7B;
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (ram_en && ram_we)  mem[ram_addr[9:0]] <= ram_wdata;
      if (ram_en && !ram_we) s1 <= mem[ram_addr[9:0]];
      s2 <= s1;
    end
  end

  int vectors_applied = 0;
  int miscompares = 0;
  int last_en_abs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Follows one granted transaction from its ACCESS cycle to its done pulse.
  task automatic serve(input logic side, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input bit toggle, input bit gap_chk);
    int cyc, en_n, en_at, en_abs;
    logic [15:0] a_s;
    logic [7:0] d_s;
    logic we_s;
    bit got;
    cyc = 0; en_n = 0; en_at = 0; en_abs = 0; a_s = '0; d_s = '0; we_s = 1'b0; got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (toggle && cyc == 1) cpu_paused = ~cpu_paused;
      if (ram_we && !ram_en) begin
        miscompares++;
        $display("FAIL we_without_en: ram_we=1 ram_en=0 (t=%0t)", $time);
      end
      if (ram_en) begin
        en_n++; en_at = cyc; en_abs = gcyc;
        a_s = ram_addr; d_s = ram_wdata; we_s = ram_we;
      end
      if (cpu_done || uart_done) begin
        got = 1'b1;
        chk("done_select", {30'd0, cpu_done, uart_done}, side ? 32'd1 : 32'd2);
        chk("owner", {31'd0, owner}, {31'd0, side});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("en_count", en_n, 32'd1);
    chk("ram_addr", {16'd0, a_s}, {16'd0, addr});
    chk("ram_we", {31'd0, we_s}, {31'd0, we});
    if (we) chk("ram_wdata", {24'd0, d_s}, {24'd0, wd});
    chk("latency", cyc - en_at, we ? 32'd1 : 32'(1 + RD_LAT));
    if (gap_chk) chk("access_gap_ge3", {31'd0, (en_abs - last_en_abs) >= 3}, 32'd1);
    last_en_abs = en_abs;
    if (side) uart_req = 1'b0; else cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        p;
    logic        cr, cw; logic [15:0] ca; logic [7:0] cd;
    logic        ur, uw; logic [15:0] ua; logic [7:0] ud;
    logic        first_uart;
    logic        tog;
    logic [7:0]  exp_c, exp_u;
  } vec_t;

  function automatic vec_t mk(logic p, logic cr, logic cw, logic [15:0] ca, logic [7:0] cd,
                              logic ur, logic uw, logic [15:0] ua, logic [7:0] ud,
                              logic fu, logic tg, logic [7:0] ec, logic [7:0] eu);
    vec_t v;
    v.p = p; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.ur = ur; v.uw = uw; v.ua = ua; v.ud = ud;
    v.first_uart = fu; v.tog = tg; v.exp_c = ec; v.exp_u = eu;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t tbl [NV];

  initial begin
    //            p  cr cw ca        cd     ur uw ua        ud     fu tg exp_c  exp_u
    tbl[0] = mk(0, 1, 1, 16'h0010, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[1] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0100, 8'h00, 1, 0, 8'h00, 8'h3C);
    tbl[2] = mk(0, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 8'hA5, 8'h3C);
    tbl[3] = mk(0, 1, 0, 16'h0200, 8'h00, 1, 0, 16'h0300, 8'h00, 0, 0, 8'h96, 8'hE1);
    tbl[4] = mk(1, 1, 1, 16'h0040, 8'h55, 1, 0, 16'h0040, 8'h00, 1, 0, 8'h96, 8'h7B);
    tbl[5] = mk(0, 1, 0, 16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h55, 8'h7B);
    tbl[6] = mk(1, 1, 0, 16'h0100, 8'h00, 1, 1, 16'h0200, 8'hEE, 1, 1, 8'h3C, 8'h7B);
    tbl[7] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0300, 8'h11, 1, 0, 8'h3C, 8'h7B);
    tbl[8] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0200, 8'h00, 1, 0, 8'h3C, 8'hEE);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {30'd0, cpu_done, uart_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_owner", {31'd0, owner}, 32'd0);
    chk("idle_rdata", {16'd0, cpu_rdata, uart_rdata}, 32'd0);
    chk("idle_ram_addr", {16'd0, ram_addr}, 32'd0);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cpu_paused = tbl[i].p;
      cpu_req  = tbl[i].cr; cpu_we  = tbl[i].cw; cpu_addr  = tbl[i].ca; cpu_wdata  = tbl[i].cd;
      uart_req = tbl[i].ur; uart_we = tbl[i].uw; uart_addr = tbl[i].ua; uart_wdata = tbl[i].ud;
      if (tbl[i].first_uart) begin
        serve(1'b1, tbl[i].uw, tbl[i].ua, tbl[i].ud, tbl[i].tog, 1'b0);
        if (tbl[i].cr) serve(1'b0, tbl[i].cw, tbl[i].ca, tbl[i].cd, 1'b0, 1'b0);
      end else begin
        serve(1'b0, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].tog, 1'b0);
        if (tbl[i].ur) serve(1'b1, tbl[i].uw, tbl[i].ua, tbl[i].ud, 1'b0, 1'b0);
      end
      chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, tbl[i].exp_c});
      chk("uart_rdata", {24'd0, uart_rdata}, {24'd0, tbl[i].exp_u});
    end

    // Back-to-back UART writes, next request raised as soon as done is seen
    @(negedge clk);
    cpu_paused = 1'b1;
    for (int k = 0; k < 4; k++) begin
      uart_req = 1'b1; uart_we = 1'b1;
      uart_addr = 16'(k); uart_wdata = 8'(8'h10 + k);
      serve(1'b1, 1'b1, 16'(k), 8'(8'h10 + k), 1'b0, k != 0);
    end
    @(negedge clk);
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 16'h0002;
    serve(1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 1'b0);
    chk("b2b_readback", {24'd0, uart_rdata}, 32'h12);

    // Reset in the middle of a UART read
    @(negedge clk);
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 16'h0100;
    @(negedge clk);
    chk("mid_access_en", {31'd0, ram_en}, 32'd1);
    @(negedge clk);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_en", {31'd0, ram_en}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {30'd0, cpu_done, uart_done}, 32'd0);
    chk("rst_mid_owner", {31'd0, owner}, 32'd0);
    chk("rst_mid_rdata", {16'd0, cpu_rdata, uart_rdata}, 32'd0);
    uart_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    cpu_paused = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    serve(1'b0, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0);
    chk("post_rst_cpu_rdata", {24'd0, cpu_rdata}, 32'hE1);
    chk("post_rst_uart_rdata", {24'd0, uart_rdata}, 32'h00);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
